except_ctrl: RTL and testbench

Parametrised, registered exception/interrupt controller sitting at the M stage of the MIPS pipeline, beside CP0. It is the successor of the combinational exception decoder. It adds:
- a synchroniser for external interrupts;
- architectural exception priority;
- EPC/BadVAddr/branch-delay computation;
- a stall-aware capture FSM that holds a detected exception until the memory stage is free, then issues a single-cycle flush/redirect pulse.

---
 rtl/except_ctrl_pkg.sv | 39 +++
 rtl/except_prio.sv | 42 ++++
 rtl/except_ctrl.sv | 155 +++++++++++++++
 tb/tb_except_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/except_ctrl_pkg.sv
// Shared ExcCodes, FSM encodings and cause-flag layout for the M-stage
// exception controller.
package except_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [31:0] EXCEPT_PC = 32'hBFC00380;

  typedef enum logic [1:0] {
    BAD_NONE,
    BAD_PC,
    BAD_DATA
  } bad_sel_e;

  // Declared highest priority first.
  typedef struct packed {
    logic intr;
    logic adel_pc;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel_data;
    logic ades;
    logic eret;
  } cause_flags_t;

endpackage

// File: rtl/except_prio.sv
// Combinational priority encoder: picks the architecturally highest cause
// and tells the controller where BadVAddr comes from.
module except_prio
  import except_ctrl_pkg::*;
(
  input  cause_flags_t flags,
  output logic         hit,
  output logic [4:0]   code,
  output bad_sel_e     bad_sel
);

  always_comb begin
    hit     = 1'b1;
    code    = EXC_INT;
    bad_sel = BAD_NONE;
    if (flags.intr) begin
      code = EXC_INT;
    end else if (flags.adel_pc) begin
      code    = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (flags.ri) begin
      code = EXC_RI;
    end else if (flags.ov) begin
      code = EXC_OV;
    end else if (flags.sys) begin
      code = EXC_SYS;
    end else if (flags.bp) begin
      code = EXC_BP;
    end else if (flags.adel_data) begin
      code    = EXC_ADEL;
      bad_sel = BAD_DATA;
    end else if (flags.ades) begin
      code    = EXC_ADES;
      bad_sel = BAD_DATA;
    end else if (flags.eret) begin
      code = EXC_ERET;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// M-stage exception/interrupt controller: synchronises interrupts, captures
// the winning cause and issues a single-cycle flush once memory is free.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int                HW_INT_W   = 6,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXCEPT_PC
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [HW_INT_W-1:0] ext_int,
  input  logic [31:0]         cp0_status,
  input  logic [31:0]         cp0_cause,
  input  logic [ADDR_W-1:0]   cp0_epc,
  input  logic                validM,
  input  logic                stallM,
  input  logic [ADDR_W-1:0]   pcM,
  input  logic [ADDR_W-1:0]   data_addrM,
  input  logic                is_in_delayslotM,
  input  logic                is_AdEL_pcM,
  input  logic                is_invalidM,
  input  logic                is_overflowM,
  input  logic                is_syscallM,
  input  logic                is_breakM,
  input  logic                is_AdEL_dataM,
  input  logic                is_AdES_dataM,
  input  logic                is_eretM,
  output logic                except_hitM,
  output logic                flush,
  output logic [ADDR_W-1:0]   except_pc,
  output logic [4:0]          except_code,
  output logic                cp0_exc_we,
  output logic                eret,
  output logic [ADDR_W-1:0]   epc_o,
  output logic                is_bd_o,
  output logic                badvaddr_we,
  output logic [ADDR_W-1:0]   badvaddr_o
);

  logic [HW_INT_W-1:0] int_sync;
  logic [HW_INT_W+1:0] int_pend;
  logic                int_take;
  cause_flags_t        flags;
  logic                prio_hit;
  logic [4:0]          prio_code;
  bad_sel_e            prio_bad_sel;

  logic [1:0]        state_reg, state_next;
  logic              capture;
  logic [4:0]        code_reg;
  logic [ADDR_W-1:0] epc_reg, bad_reg, target_reg;
  logic              bd_reg, bad_we_reg, is_eret_reg;

  for (genvar gi = 0; gi < HW_INT_W; gi++) begin : g_sync
    logic meta_reg, sync_reg;
    always_ff @(posedge clk) begin
      if (!resetn) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= ext_int[gi];
        sync_reg <= meta_reg;
      end
    end
    assign int_sync[gi] = sync_reg;
  end

  // Software IP bits sit below the hardware lines, matching the IM layout.
  assign int_pend = cp0_status[8+HW_INT_W+1:8] & {int_sync, cp0_cause[9:8]};
  assign int_take = (|int_pend) && cp0_status[0] && !cp0_status[1];

  always_comb begin
    flags = '0;
    if (validM) begin
      flags.intr      = int_take;
      flags.adel_pc   = is_AdEL_pcM;
      flags.ri        = is_invalidM;
      flags.ov        = is_overflowM;
      flags.sys       = is_syscallM;
      flags.bp        = is_breakM;
      flags.adel_data = is_AdEL_dataM;
      flags.ades      = is_AdES_dataM;
      flags.eret      = is_eretM;
    end
  end

  except_prio u_prio (
    .flags   (flags),
    .hit     (prio_hit),
    .code    (prio_code),
    .bad_sel (prio_bad_sel)
  );

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (prio_hit) begin
          capture    = 1'b1;
          state_next = stallM ? HOLD : COMMIT;
        end
      end
      HOLD:    if (!stallM) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      code_reg    <= '0;
      epc_reg     <= '0;
      bad_reg     <= '0;
      target_reg  <= '0;
      bd_reg      <= 1'b0;
      bad_we_reg  <= 1'b0;
      is_eret_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        code_reg    <= prio_code;
        epc_reg     <= is_in_delayslotM ? pcM - ADDR_W'(4) : pcM;
        bd_reg      <= is_in_delayslotM;
        bad_we_reg  <= (prio_bad_sel != BAD_NONE);
        is_eret_reg <= (prio_code == EXC_ERET);
        target_reg  <= (prio_code == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        case (prio_bad_sel)
          BAD_PC:   bad_reg <= pcM;
          BAD_DATA: bad_reg <= data_addrM;
          default:  bad_reg <= bad_reg;
        endcase
      end
    end
  end

  // The commit cycle belongs to an already-reported exception.
  assign except_hitM = prio_hit && (state_reg != COMMIT);
  assign flush       = (state_reg == COMMIT);
  assign cp0_exc_we  = flush && !is_eret_reg;
  assign eret        = flush && is_eret_reg;
  assign badvaddr_we = flush && bad_we_reg;
  assign except_pc   = target_reg;
  assign except_code = code_reg;
  assign epc_o       = epc_reg;
  assign is_bd_o     = bd_reg;
  assign badvaddr_o  = bad_reg;

  logic unused_ok;
  assign unused_ok = &{1'b0, cp0_status[31:HW_INT_W+10], cp0_status[7:2],
                       cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl with a cycle-level reference model of the
// capture/commit behaviour and literal checks of the listed scenarios.
module tb_except_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [5:0]  ext_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, pcM, data_addrM;
  logic        validM, stallM, is_in_delayslotM;
  logic        is_AdEL_pcM, is_invalidM, is_overflowM, is_syscallM;
  logic        is_breakM, is_AdEL_dataM, is_AdES_dataM, is_eretM;
  logic        except_hitM, flush, cp0_exc_we, eret, is_bd_o, badvaddr_we;
  logic [31:0] except_pc, epc_o, badvaddr_o;
  logic [4:0]  except_code;

  except_ctrl #(.HW_INT_W(6), .ADDR_W(32), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .resetn(resetn), .ext_int(ext_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .validM(validM), .stallM(stallM), .pcM(pcM), .data_addrM(data_addrM),
    .is_in_delayslotM(is_in_delayslotM), .is_AdEL_pcM(is_AdEL_pcM),
    .is_invalidM(is_invalidM), .is_overflowM(is_overflowM),
    .is_syscallM(is_syscallM), .is_breakM(is_breakM),
    .is_AdEL_dataM(is_AdEL_dataM), .is_AdES_dataM(is_AdES_dataM),
    .is_eretM(is_eretM), .except_hitM(except_hitM), .flush(flush),
    .except_pc(except_pc), .except_code(except_code), .cp0_exc_we(cp0_exc_we),
    .eret(eret), .epc_o(epc_o), .is_bd_o(is_bd_o),
    .badvaddr_we(badvaddr_we), .badvaddr_o(badvaddr_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a pending exception record plus an interrupt delay line.
  logic [4:0]  code_tab [9] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, 5'h0e};
  logic [5:0]  m_s1 = '0, m_s2 = '0;
  logic        m_live = 1'b0, m_wait = 1'b0, m_commit = 1'b0;
  logic        m_eret = 1'b0, m_badwe = 1'b0, m_bd = 1'b0;
  logic [4:0]  m_code = '0;
  logic [31:0] m_pc = '0, m_epc = '0, m_bad = '0;
  logic        prev_flush = 1'b0;

  function automatic int first_cause();
    logic [8:0] f;
    logic [7:0] pend;
    if (!validM) return -1;
    pend = cp0_status[15:8] & {m_s2, cp0_cause[9:8]};
    f[0] = (pend != 0) && cp0_status[0] && !cp0_status[1];
    f[1] = is_AdEL_pcM;   f[2] = is_invalidM;   f[3] = is_overflowM;
    f[4] = is_syscallM;   f[5] = is_breakM;     f[6] = is_AdEL_dataM;
    f[7] = is_AdES_dataM; f[8] = is_eretM;
    for (int i = 0; i < 9; i++) if (f[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    int k;
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_wait = 0; m_commit = 0;
    end else begin
      k = first_cause();
      if (m_commit) begin
        m_commit = 0;
      end else if (m_wait) begin
        if (!stallM) begin m_wait = 0; m_commit = 1; end
      end else if (k >= 0) begin
        m_code  = code_tab[k];
        m_epc   = is_in_delayslotM ? pcM - 32'd4 : pcM;
        m_bd    = is_in_delayslotM;
        m_eret  = (k == 8);
        m_pc    = (k == 8) ? cp0_epc : 32'hBFC00380;
        m_badwe = (k == 1) || (k == 6) || (k == 7);
        m_bad   = (k == 1) ? pcM : data_addrM;
        if (stallM) m_wait = 1; else m_commit = 1;
      end
      m_s2 = m_s1;
      m_s1 = ext_int;
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("flush", flush, m_commit);
      chk("cp0_exc_we", cp0_exc_we, m_commit && !m_eret);
      chk("eret", eret, m_commit && m_eret);
      chk("badvaddr_we", badvaddr_we, m_commit && m_badwe);
      chk("except_hitM", except_hitM, !m_commit && (first_cause() >= 0));
      chk("no_back_to_back_flush", flush && prev_flush, 1'b0);
      if (m_commit) begin
        chk("except_code", except_code, m_code);
        chk("except_pc", except_pc, m_pc);
        chk("epc_o", epc_o, m_epc);
        chk("is_bd_o", is_bd_o, m_bd);
        if (m_badwe) chk("badvaddr_o", badvaddr_o, m_bad);
      end
      prev_flush = flush;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    validM = 0; stallM = 0; is_in_delayslotM = 0;
    is_AdEL_pcM = 0; is_invalidM = 0; is_overflowM = 0; is_syscallM = 0;
    is_breakM = 0; is_AdEL_dataM = 0; is_AdES_dataM = 0; is_eretM = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_except_pc"}, except_pc, 0);
    chk({tag, "_except_code"}, except_code, 0);
    chk({tag, "_epc_o"}, epc_o, 0);
    chk({tag, "_badvaddr_o"}, badvaddr_o, 0);
    chk({tag, "_is_bd_o"}, is_bd_o, 0);
    chk({tag, "_we"}, cp0_exc_we | badvaddr_we | eret, 0);
  endtask

  initial begin
    int nflush;
    clear();
    resetn = 0; ext_int = '0; cp0_status = 32'h0000FF01; cp0_cause = '0;
    cp0_epc = '0; pcM = '0; data_addrM = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    $display("txn reset: outputs cleared");
    resetn = 1;
    tick();

    // Syscall in a delay slot, no stall.
    validM = 1; is_syscallM = 1; pcM = 32'hBFC00100; is_in_delayslotM = 1;
    tick(); clear();
    chk("sys_flush", flush, 1);
    chk("sys_code", except_code, 5'h08);
    chk("sys_epc", epc_o, 32'hBFC000FC);
    chk("sys_bd", is_bd_o, 1);
    chk("sys_pc", except_pc, 32'hBFC00380);
    chk("sys_we", cp0_exc_we, 1);
    chk("sys_bvwe", badvaddr_we, 0);
    $display("txn syscall: code=%h epc=%h bd=%0d", except_code, epc_o, is_bd_o);
    tick();
    chk("sys_single_pulse", flush, 0);

    // Overflow beats AdES.
    validM = 1; is_overflowM = 1; is_AdES_dataM = 1;
    pcM = 32'hBFC00204; data_addrM = 32'h80000003;
    tick(); clear();
    chk("ov_flush", flush, 1);
    chk("ov_code", except_code, 5'h0c);
    chk("ov_bvwe", badvaddr_we, 0);
    chk("ov_epc", epc_o, 32'hBFC00204);
    $display("txn ov+ades: code=%h", except_code);
    tick();

    // AdEL fetch beats RI; BadVAddr from the PC.
    validM = 1; is_AdEL_pcM = 1; is_invalidM = 1; pcM = 32'hBFC00002;
    data_addrM = 32'h00000040;
    tick(); clear();
    chk("adelpc_code", except_code, 5'h04);
    chk("adelpc_bvwe", badvaddr_we, 1);
    chk("adelpc_bad", badvaddr_o, 32'hBFC00002);
    $display("txn adel_pc+ri: code=%h bad=%h", except_code, badvaddr_o);
    tick();

    // AdEL data held through a 3-cycle stall while the M flags change.
    validM = 1; is_AdEL_dataM = 1; data_addrM = 32'h00001001;
    pcM = 32'hBFC00300; stallM = 1;
    tick();
    is_AdEL_dataM = 0; is_syscallM = 1; data_addrM = 32'hDEADBEEF; pcM = 32'hBFC00500;
    nflush = int'(flush);
    tick(); nflush += int'(flush);
    tick(); stallM = 0; nflush += int'(flush);
    tick();
    chk("hold_no_early_flush", nflush, 0);
    chk("hold_flush", flush, 1);
    chk("hold_code", except_code, 5'h04);
    chk("hold_bad", badvaddr_o, 32'h00001001);
    chk("hold_bvwe", badvaddr_we, 1);
    chk("hold_epc", epc_o, 32'hBFC00300);
    $display("txn adel_data stalled: code=%h bad=%h", except_code, badvaddr_o);
    clear(); tick();
    chk("hold_single_pulse", flush, 0);
    tick();

    // External interrupt through the synchroniser.
    validM = 1; pcM = 32'hBFC00400; ext_int = 6'b000001;
    nflush = 0;
    tick(); nflush += int'(flush);
    tick(); nflush += int'(flush);
    tick();
    chk("int_early", nflush, 0);
    chk("int_flush", flush, 1);
    chk("int_code", except_code, 5'h00);
    chk("int_we", cp0_exc_we, 1);
    $display("txn ext_int: code=%h", except_code);
    ext_int = '0; clear();
    repeat (3) tick();

    // Masked by EXL.
    cp0_status = 32'h0000FF03; validM = 1; ext_int = 6'b000001;
    nflush = 0;
    repeat (5) begin tick(); nflush += int'(flush); end
    chk("exl_no_flush", nflush, 0);
    $display("txn ext_int exl=1: flushes=%0d", nflush);
    ext_int = '0; clear(); cp0_status = 32'h0000FF01;
    repeat (3) tick();

    // Software interrupt IP0.
    cp0_cause = 32'h00000100; validM = 1; pcM = 32'hBFC00600;
    tick(); clear(); cp0_cause = '0;
    chk("swint_flush", flush, 1);
    chk("swint_code", except_code, 5'h00);
    $display("txn sw_int: code=%h", except_code);
    tick();

    // ERET: target is EPC sampled at capture.
    cp0_epc = 32'hBFC00200; validM = 1; is_eretM = 1; pcM = 32'hBFC00700;
    tick(); clear(); cp0_epc = 32'h12345678;
    chk("eret_flush", flush, 1);
    chk("eret_pulse", eret, 1);
    chk("eret_we", cp0_exc_we, 0);
    chk("eret_pc", except_pc, 32'hBFC00200);
    chk("eret_code", except_code, 5'h0e);
    $display("txn eret: pc=%h", except_pc);
    tick();

    // Reset while holding aborts the exception.
    validM = 1; is_syscallM = 1; pcM = 32'hBFC00800; stallM = 1;
    tick();
    resetn = 0;
    tick();
    resetn = 1; clear();
    nflush = 0;
    repeat (3) begin tick(); nflush += int'(flush); end
    chk("rst_hold_no_flush", nflush, 0);
    chk_all_zero("rst_hold");
    $display("txn reset during hold: flushes=%0d", nflush);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
